// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access sizes, FSM states,
// write-back constants and the alignment rule.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } lsu_state_e;

  localparam logic [63:0] ZeroWord     = 64'd0;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // off is the byte offset zero-extended to 3 bits; a dword on a 32-bit bus can never be aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off,
                                      input int data_w);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      default: m = (data_w == 32) || (|off);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational byte-lane logic (store replication, byte enables,
// load extraction with sign/zero extension) for any power-of-two bus width.
module lsu_align #(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [LANES-1:0]  sel_o,
  output logic [DATA_W-1:0] ldata_o
);

  int                sz;
  int                nbytes;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    // Sizes wider than the bus are clamped so indexing stays in range; such accesses are misaligned anyway.
    sz       = (int'(size_i) > OFF_W) ? OFF_W : int'(size_i);
    nbytes   = 1 << sz;
    shifted  = rdata_i >> {off_i, 3'b000};
    sign_bit = ~unsigned_i & shifted[8*nbytes-1];
    wdata_o  = '0;
    sel_o    = '0;
    ldata_o  = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata_o[8*i +: 8] = sdata_i[8*(i & (nbytes-1)) +: 8];
      sel_o[i]          = (i >= int'(off_i)) && (i < int'(off_i) + nbytes);
    end
    for (int j = 0; j < DATA_W; j++) begin
      ldata_o[j] = (j < 8*nbytes) ? shifted[j] : sign_bit;
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle MEM-stage load/store unit with a req/ack memory port and registered write-back.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into a fault pulse.
//
// Handshakes: an instruction is taken when in_valid && in_ready; in_ready is high only in IDLE.
// Memory: mem_req stays high with stable mem_* until the cycle mem_ack is seen.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_sdata,
  input  logic [4:0]        in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              wbv_q, wbv_d;
  logic [4:0]        wbwd_q, wbwd_d;
  logic              wbwreg_q, wbwreg_d;
  logic [DATA_W-1:0] wbdata_q, wbdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
`endif

  logic [1:0]        al_size;
  logic [OFF_W-1:0]  al_off;
  logic [DATA_W-1:0] al_wdata, al_ldata;
  logic [LANES-1:0]  al_sel;
  logic              mis;

  // In IDLE the lane logic shapes the incoming store; in REQ it extracts the returning load.
  assign al_size = (state_q == ST_REQ) ? size_q : in_size;
  assign al_off  = (state_q == ST_REQ) ? off_q : in_addr[OFF_W-1:0];
  assign mis     = misaligned(in_size, 3'(in_addr[OFF_W-1:0]), DATA_W);

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size_i     (al_size),
    .unsigned_i (uns_q),
    .off_i      (al_off),
    .sdata_i    (in_sdata),
    .rdata_i    (mem_rdata),
    .wdata_o    (al_wdata),
    .sel_o      (al_sel),
    .ldata_o    (al_ldata)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    mwdata_d = mwdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    wbv_d    = 1'b0;
    wbwd_d   = wbwd_q;
    wbwreg_d = wbwreg_q;
    wbdata_d = wbdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d  = 1'b0;
    faddr_d  = faddr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          wbwd_d = in_wd;
          if (!(in_load || in_store)) begin
            wbv_d    = 1'b1;
            wbwreg_d = in_wreg;
            wbdata_d = in_wdata;
          end else if (mis) begin
            wbv_d    = 1'b1;
            wbdata_d = ZeroWord[DATA_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
            wbwreg_d = WriteDisable;
            fault_d  = 1'b1;
            faddr_d  = in_addr;
`else
            wbwreg_d = in_store ? WriteDisable : in_wreg;
`endif
          end else begin
            // A combined load+store flag is executed as a store.
            state_d  = ST_REQ;
            we_d     = in_store;
            addr_d   = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            sel_d    = al_sel;
            mwdata_d = al_wdata;
            size_d   = in_size;
            uns_d    = in_unsigned;
            off_d    = in_addr[OFF_W-1:0];
            wd_d     = in_wd;
            wreg_d   = in_wreg;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d  = ST_IDLE;
          wbv_d    = 1'b1;
          wbwd_d   = wd_q;
          wbwreg_d = we_q ? WriteDisable : wreg_q;
          wbdata_d = we_q ? ZeroWord[DATA_W-1:0] : al_ldata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      mwdata_q <= '0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      off_q    <= '0;
      wd_q     <= NOPRegAddr;
      wreg_q   <= WriteDisable;
      wbv_q    <= 1'b0;
      wbwd_q   <= NOPRegAddr;
      wbwreg_q <= WriteDisable;
      wbdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
      faddr_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      mwdata_q <= mwdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      wbv_q    <= wbv_d;
      wbwd_q   <= wbwd_d;
      wbwreg_q <= wbwreg_d;
      wbdata_q <= wbdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= fault_d;
      faddr_q  <= faddr_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_sel   = sel_q;
  assign mem_wdata = mwdata_q;
  assign wb_valid  = wbv_q;
  assign wb_wd     = wbwd_q;
  assign wb_wreg   = wbwreg_q;
  assign wb_wdata  = wbdata_q;
  assign dbg_state = state_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign fault      = fault_q;
  assign fault_addr = faddr_q;
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: table of accesses with a write-back scoreboard, plus hand sequences
// for back-to-back ALU ops, reset during an access and a 64-bit instance.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_load = 0, in_store = 0, in_unsigned = 0, in_wreg = 0;
  logic [1:0]  in_size = 0;
  logic [31:0] in_addr = 0, in_sdata = 0, in_wdata = 0;
  logic [4:0]  in_wd = 0;
  logic        in_ready, mem_req, mem_we, wb_valid, wb_wreg, fault;
  logic [31:0] mem_addr, mem_wdata, wb_wdata, fault_addr;
  logic [3:0]  mem_sel;
  logic        mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  logic [4:0]  wb_wd;
  lsu_state_e  dbg_state;

  mem_lsu #(.DATA_W(32), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_sdata(in_sdata), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .fault(fault),
    .fault_addr(fault_addr), .dbg_state(dbg_state)
  );

  logic        v64 = 0, ld64 = 0, ack64 = 0;
  logic [1:0]  sz64 = 0;
  logic        uns64 = 0;
  logic [31:0] addr64 = 0;
  logic [63:0] rdata64 = 0;
  logic        rdy64, req64, we64, wbv64, wreg64, fault64;
  logic [31:0] maddr64, faddr64;
  logic [7:0]  sel64;
  logic [63:0] mwdata64, wbdata64;
  logic [4:0]  wd64;
  lsu_state_e  st64;

  mem_lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_load(ld64),
    .in_store(1'b0), .in_size(sz64), .in_unsigned(uns64), .in_addr(addr64),
    .in_sdata(64'd0), .in_wd(5'd3), .in_wreg(1'b1), .in_wdata(64'd0),
    .mem_req(req64), .mem_we(we64), .mem_addr(maddr64), .mem_sel(sel64),
    .mem_wdata(mwdata64), .mem_ack(ack64), .mem_rdata(rdata64), .wb_valid(wbv64),
    .wb_wd(wd64), .wb_wreg(wreg64), .wb_wdata(wbdata64), .fault(fault64),
    .fault_addr(faddr64), .dbg_state(st64)
  );

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];  // {wd, wreg, wdata}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got wb_valid=1 wd=%0d expected no write-back", wb_wd);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("sb_wd", 64'(wb_wd), 64'(e[37:33]));
        chk("sb_wreg", 64'(wb_wreg), 64'(e[32]));
        if (e[32]) chk("sb_wdata", 64'(wb_wdata), 64'(e[31:0]));
      end
    end
  end

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] alu;
    int          ack_dly;
    logic        mis;
    logic        exp_we;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_mwdata;
    logic        exp_wreg;   // value without the misalignment trap
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[15];

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic exp_req, exp_fault, ew;
    int   lowcnt;
    exp_req   = (v.ld || v.st) && !v.mis;
    exp_fault = TRAP && v.mis;
    ew        = (TRAP && v.mis) ? 1'b0 : v.exp_wreg;
    wait_ready();
    in_valid = 1; in_load = v.ld; in_store = v.st; in_size = v.sz; in_unsigned = v.uns;
    in_addr = v.addr; in_sdata = v.sdata; in_wd = v.wd; in_wreg = v.wreg; in_wdata = v.alu;
    exp_q.push_back({v.wd, ew, v.exp_wdata});
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    if (exp_req) begin
      chk($sformatf("v%0d_req", idx), 64'(mem_req), 64'd1);
      chk($sformatf("v%0d_we", idx), 64'(mem_we), 64'(v.exp_we));
      chk($sformatf("v%0d_maddr", idx), 64'(mem_addr), 64'(v.exp_maddr));
      if (v.st) begin
        chk($sformatf("v%0d_sel", idx), 64'(mem_sel), 64'(v.exp_sel));
        chk($sformatf("v%0d_mwdata", idx), 64'(mem_wdata), 64'(v.exp_mwdata));
      end
      lowcnt = 0;
      for (int k = 0; k <= v.ack_dly; k++) begin
        if (k > 0) @(negedge clk);
        if (!in_ready) lowcnt++;
        if (k == v.ack_dly) begin
          mem_ack = 1; mem_rdata = v.rdata;
        end
      end
      @(posedge clk); #1 mem_ack = 0;
      @(negedge clk);
      chk($sformatf("v%0d_stall", idx), 64'(lowcnt), 64'(v.ack_dly + 1));
    end else begin
      chk($sformatf("v%0d_noreq", idx), 64'(mem_req), 64'd0);
    end
    chk($sformatf("v%0d_wb_lat", idx), 64'(wb_valid), 64'd1);
    chk($sformatf("v%0d_fault", idx), 64'(fault), 64'(exp_fault));
    chk($sformatf("v%0d_faddr", idx), 64'(fault_addr), exp_fault ? 64'(v.addr) : 64'd0);
  endtask

  initial begin
    //          ld st sz uns addr       sdata         rdata         wd wr alu           dly mis we maddr      sel   mwdata        wreg wdata
    vecs[0]  = '{1, 0, 0, 0, 32'h103, 32'h0,        32'h80AA5500, 5,  1, 32'h0,        0, 0, 0, 32'h100, 4'h0, 32'h0,        1, 32'hFFFFFF80};
    vecs[1]  = '{0, 1, 1, 0, 32'h202, 32'h1234BEEF, 32'h0,        6,  1, 32'h0,        3, 0, 1, 32'h200, 4'hC, 32'hBEEFBEEF, 0, 32'h0};
    vecs[2]  = '{1, 0, 0, 1, 32'h101, 32'h0,        32'h1234F678, 7,  1, 32'h0,        1, 0, 0, 32'h100, 4'h0, 32'h0,        1, 32'h000000F6};
    vecs[3]  = '{1, 0, 1, 0, 32'h102, 32'h0,        32'h80017FFF, 8,  1, 32'h0,        0, 0, 0, 32'h100, 4'h0, 32'h0,        1, 32'hFFFF8001};
    vecs[4]  = '{1, 0, 1, 1, 32'h100, 32'h0,        32'h80019ABC, 9,  1, 32'h0,        2, 0, 0, 32'h100, 4'h0, 32'h0,        1, 32'h00009ABC};
    vecs[5]  = '{1, 0, 2, 0, 32'h104, 32'h0,        32'hDEADBEEF, 10, 1, 32'h0,        0, 0, 0, 32'h104, 4'h0, 32'h0,        1, 32'hDEADBEEF};
    vecs[6]  = '{0, 1, 0, 0, 32'h301, 32'hAABBCC5A, 32'h0,        11, 1, 32'h0,        1, 0, 1, 32'h300, 4'h2, 32'h5A5A5A5A, 0, 32'h0};
    vecs[7]  = '{0, 1, 2, 0, 32'h400, 32'hCAFEF00D, 32'h0,        12, 1, 32'h0,        0, 0, 1, 32'h400, 4'hF, 32'hCAFEF00D, 0, 32'h0};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        13, 1, 32'h12345678, 0, 0, 0, 32'h0,   4'h0, 32'h0,        1, 32'h12345678};
    vecs[9]  = '{1, 0, 2, 0, 32'h101, 32'h0,        32'h0,        14, 1, 32'h0,        0, 1, 0, 32'h0,   4'h0, 32'h0,        1, 32'h0};
    vecs[10] = '{0, 1, 1, 0, 32'h203, 32'h5555,     32'h0,        15, 1, 32'h0,        0, 1, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};
    vecs[11] = '{1, 0, 3, 0, 32'h100, 32'h0,        32'h0,        16, 1, 32'h0,        0, 1, 0, 32'h0,   4'h0, 32'h0,        1, 32'h0};
    vecs[12] = '{1, 1, 2, 0, 32'h208, 32'h11223344, 32'h0,        17, 1, 32'h0,        1, 0, 1, 32'h208, 4'hF, 32'h11223344, 0, 32'h0};
    vecs[13] = '{1, 0, 0, 0, 32'h102, 32'h0,        32'h007F0000, 18, 1, 32'h0,        0, 0, 0, 32'h100, 4'h0, 32'h0,        1, 32'h0000007F};
    vecs[14] = '{0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        19, 0, 32'hAAAA5555, 0, 0, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_wbv", 64'(wb_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // ALU ops streamed with in_valid held: one write-back per cycle, never stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_load = 0; in_store = 0; in_wd = 5'(20 + i); in_wreg = 1;
      in_wdata = 32'h100 + 32'(i) * 32'h11;
      exp_q.push_back({5'(20 + i), 1'b1, 32'h100 + 32'(i) * 32'h11});
      @(negedge clk);
      chk("b2b_ready", 64'(in_ready), 64'd1);
      chk("b2b_wbv", 64'(wb_valid), 64'd1);
    end
    in_valid = 0;
    @(negedge clk);
    chk("b2b_end", 64'(wb_valid), 64'd0);

    // Reset while a load waits for its ack; the late ack must be ignored.
    in_valid = 1; in_load = 1; in_store = 0; in_size = SZ_W; in_addr = 32'h500; in_wd = 5'd9;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("mid_req", 64'(mem_req), 64'd1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_wbv", 64'(wb_valid), 64'd0);
    rst = 0; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_ack = 0;
    @(negedge clk);
    chk("late_ack_wbv", 64'(wb_valid), 64'd0);
    chk("late_ack_req", 64'(mem_req), 64'd0);

    // 64-bit bus: LHU from the top half-word lanes.
    v64 = 1; ld64 = 1; sz64 = SZ_H; uns64 = 1; addr64 = 32'h6;
    @(posedge clk); #1 v64 = 0;
    @(negedge clk);
    chk("d64_req", 64'(req64), 64'd1);
    chk("d64_we", 64'(we64), 64'd0);
    chk("d64_maddr", 64'(maddr64), 64'd0);
    ack64 = 1; rdata64 = 64'hF00D_0000_0000_0000;
    @(posedge clk); #1 ack64 = 0;
    @(negedge clk);
    chk("d64_wbv", 64'(wbv64), 64'd1);
    chk("d64_wreg", 64'(wreg64), 64'd1);
    chk("d64_wdata", wbdata64, 64'h0000_0000_0000_F00D);
    @(negedge clk);
    chk("d64_pulse", 64'(wbv64), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
